// File: rtl/spi_ram_ctrl.sv
// Command-decoding byte memory behind an SPI slave: write/read address and data opcodes.
// Optional feature macro SPI_RAM_AUTOINC_EN: post-increment (with wrap) of addresses after data accesses.
module spi_ram_ctrl #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       err
);

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  logic                 rx_q, rx_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_ok_q, wr_ok_d;
  logic                 rd_ok_q, rd_ok_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 err_q, err_d;

  logic [7:0]           mem_q [MEM_DEPTH];
  logic                 mem_we;
  logic [7:0]           mem_wdata;

  logic                 accept;
  logic                 addr_in_range;
  logic [ADDR_SIZE-1:0] payload_addr;
  op_e                  op;

`ifdef SPI_RAM_AUTOINC_EN
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] ONE_ADDR  = ADDR_SIZE'(1);

  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ONE_ADDR;
  endfunction
`endif

  assign accept        = rx_valid & ~rx_q;
  assign op            = op_e'(din[9:8]);
  assign payload_addr  = din[ADDR_SIZE-1:0];
  assign addr_in_range = (32'(din[7:0]) < MEM_DEPTH);

  always_comb begin
    rx_d       = rx_valid;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_ok_d    = wr_ok_q;
    rd_ok_d    = rd_ok_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = din[7:0];

    // Any accepted command drops tx_valid; a successful read-data raises it again on the same edge.
    if (accept) begin
      tx_valid_d = 1'b0;
      unique case (op)
        OP_WR_ADDR: begin
          if (addr_in_range) begin
            wr_addr_d = payload_addr;
            wr_ok_d   = 1'b1;
          end else begin
            wr_ok_d = 1'b0;
            err_d   = 1'b1;
          end
        end
        OP_WR_DATA: begin
          if (wr_ok_q) begin
            mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            wr_addr_d = next_addr(wr_addr_q);
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        OP_RD_ADDR: begin
          if (addr_in_range) begin
            rd_addr_d = payload_addr;
            rd_ok_d   = 1'b1;
          end else begin
            rd_ok_d = 1'b0;
            err_d   = 1'b1;
          end
        end
        OP_RD_DATA: begin
          if (rd_ok_q) begin
            dout_d     = mem_q[rd_addr_q];
            tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            rd_addr_d = next_addr(rd_addr_q);
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // rx_q resets high so a level held through reset is not mistaken for a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q       <= 1'b1;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_ok_q    <= 1'b0;
      rd_ok_q    <= 1'b0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_q       <= rx_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_ok_q    <= wr_ok_d;
      rd_ok_q    <= rd_ok_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[wr_addr_q] <= mem_wdata;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: directed table, corner sequences and randomized commands vs a reference model.
module tb_spi_ram_ctrl;

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] din;
  logic       rx_valid, rx_valid2;
  logic [7:0] dout, dout2;
  logic       tx_valid, tx_valid2;
  logic       err, err2;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout), .tx_valid(tx_valid), .err(err)
  );

  spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8)) dut200 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid2),
    .dout(dout2), .tx_valid(tx_valid2), .err(err2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [9:0] w;
    logic       e_err;
    logic       e_tx;
    logic [7:0] e_dout;
  } vec_t;

  vec_t tbl[10];

  // reference model state
  logic [7:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  int         m_wr, m_rd;
  bit         m_wok, m_rok;
  logic [7:0] m_dout;
  bit         m_dout_known;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic hold_rx);
    @(negedge clk);
    rst = 1'b1; rx_valid = hold_rx; rx_valid2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise rx_valid at a negedge; return at the following negedge (cycle A+1).
  task automatic start(input logic [9:0] w, input bit sel2);
    @(negedge clk);
    din = w;
    if (sel2) rx_valid2 = 1'b1; else rx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic finish_cmd(input bit sel2, input int extra);
    @(negedge clk);
    chk("err_one_cycle", sel2 ? {7'd0, err2} : {7'd0, err}, 8'd0);
    repeat (extra) @(negedge clk);
    if (sel2) rx_valid2 = 1'b0; else rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic cmd_read(input logic [9:0] w, input bit sel2, output logic e, output logic t, output logic [7:0] d);
    start(w, sel2);
    e = sel2 ? err2 : err;
    t = sel2 ? tx_valid2 : tx_valid;
    d = sel2 ? dout2 : dout;
    finish_cmd(sel2, 0);
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_wok = 0; m_rok = 0;
    m_dout = 8'h00; m_dout_known = 1;
  endtask

  task automatic model_cmd(input logic [9:0] w, output logic e_err, output logic e_tx);
    int a;
    a = int'(w[7:0]);
    e_err = 1'b0;
    e_tx  = 1'b0;
    case (w[9:8])
      2'b00: if (a < DEPTH) begin m_wr = a; m_wok = 1; end else begin m_wok = 0; e_err = 1'b1; end
      2'b01: if (m_wok) begin
               m_mem[m_wr] = w[7:0]; m_known[m_wr] = 1;
               if (AUTOINC) m_wr = (m_wr + 1) % DEPTH;
             end else e_err = 1'b1;
      2'b10: if (a < DEPTH) begin m_rd = a; m_rok = 1; end else begin m_rok = 0; e_err = 1'b1; end
      default: if (m_rok) begin
               m_dout = m_mem[m_rd]; m_dout_known = m_known[m_rd]; e_tx = 1'b1;
               if (AUTOINC) m_rd = (m_rd + 1) % DEPTH;
             end else e_err = 1'b1;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       e, t, ee, et;
    logic [7:0] d, exp_first;
    logic [9:0] w;
    int         a;

    tbl[0] = '{10'h300, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{10'h155, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{10'h200, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{10'h300, 1'b0, 1'b1, 8'hxx};
    tbl[4] = '{10'h03C, 1'b0, 1'b0, 8'hxx};
    tbl[5] = '{10'h23C, 1'b0, 1'b0, 8'hxx};
    tbl[6] = '{10'h1A5, 1'b0, 1'b0, 8'hxx};
    tbl[7] = '{10'h300, 1'b0, 1'b1, 8'hA5};
    tbl[8] = '{10'h300, 1'b0, 1'b1, 8'hA5};
    tbl[9] = '{10'h010, 1'b0, 1'b0, 8'hA5};

    rst = 1'b0; din = 10'h300; rx_valid = 1'b0; rx_valid2 = 1'b0;

    // Reset with rx_valid held high: reset values, and no accept afterwards.
    do_reset(1'b1);
    chk("rst_dout", dout, 8'h00);
    chk("rst_tx", {7'd0, tx_valid}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    repeat (2) begin
      @(negedge clk);
      chk("held_rx_no_accept", {7'd0, err}, 8'd0);
    end
    rx_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      cmd_read(tbl[i].w, 1'b0, e, t, d);
      chk($sformatf("tbl%0d_err", i), {7'd0, e}, {7'd0, tbl[i].e_err});
      chk($sformatf("tbl%0d_tx", i), {7'd0, t}, {7'd0, tbl[i].e_tx});
      chk($sformatf("tbl%0d_dout", i), d, tbl[i].e_dout);
    end

    // Long rx_valid level: one write only.
    start(10'h177, 1'b0);
    chk("hold_err", {7'd0, err}, 8'd0);
    repeat (19) @(negedge clk);
    chk("hold_err_end", {7'd0, err}, 8'd0);
    rx_valid = 1'b0;
    @(negedge clk);
    cmd_read(10'h210, 1'b0, e, t, d);
    cmd_read(10'h300, 1'b0, e, t, d);
    chk("hold_dout", d, 8'h77);
    chk("hold_tx", {7'd0, t}, 8'd1);
    cmd_read(10'h211, 1'b0, e, t, d);
    cmd_read(10'h300, 1'b0, e, t, d);
    chk("hold_neighbour", d, 8'hxx);

    // Burst sequence across the top address.
    exp_first = AUTOINC ? 8'h11 : 8'h22;
    cmd_read(10'h0FF, 1'b0, e, t, d);
    cmd_read(10'h111, 1'b0, e, t, d);
    cmd_read(10'h122, 1'b0, e, t, d);
    cmd_read(10'h2FF, 1'b0, e, t, d);
    cmd_read(10'h300, 1'b0, e, t, d);
    chk("burst_rd0", d, exp_first);
    cmd_read(10'h300, 1'b0, e, t, d);
    chk("burst_rd1", d, 8'h22);
    chk("burst_err", {7'd0, e}, 8'd0);

    // Reset in cycle A of a write-data, rx_valid kept high through reset.
    cmd_read(10'h020, 1'b0, e, t, d);
    cmd_read(10'h15A, 1'b0, e, t, d);
    @(negedge clk);
    din = 10'h1EE; rx_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstA_dout", dout, 8'h00);
    chk("rstA_tx", {7'd0, tx_valid}, 8'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rstA_no_accept", {7'd0, err}, 8'd0);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    cmd_read(10'h1EE, 1'b0, e, t, d);
    chk("rstA_fresh_edge_err", {7'd0, e}, 8'd1);
    cmd_read(10'h220, 1'b0, e, t, d);
    cmd_read(10'h300, 1'b0, e, t, d);
    chk("rstA_mem", d, 8'h5A);

    // MEM_DEPTH = 200 instance: range boundary.
    cmd_read(10'h0C8, 1'b1, e, t, d);
    chk("d200_oor_err", {7'd0, e}, 8'd1);
    cmd_read(10'h133, 1'b1, e, t, d);
    chk("d200_wd_err", {7'd0, e}, 8'd1);
    cmd_read(10'h0C7, 1'b1, e, t, d);
    chk("d200_top_ok", {7'd0, e}, 8'd0);
    cmd_read(10'h133, 1'b1, e, t, d);
    cmd_read(10'h2C7, 1'b1, e, t, d);
    cmd_read(10'h300, 1'b1, e, t, d);
    chk("d200_rd", d, 8'h33);
    chk("d200_tx", {7'd0, t}, 8'd1);

    // Randomized commands against the model.
    do_reset(1'b0);
    model_reset();
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(250, 255) : $urandom_range(0, 5);
      w[9:8] = 2'($urandom_range(0, 3));
      w[7:0] = (w[9:8] == 2'b01) ? 8'($urandom) : 8'(a);
      model_cmd(w, ee, et);
      start(w, 1'b0);
      chk("rnd_err", {7'd0, err}, {7'd0, ee});
      chk("rnd_tx", {7'd0, tx_valid}, {7'd0, et});
      if (m_dout_known) chk("rnd_dout", dout, m_dout);
      finish_cmd(1'b0, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
